// File: rtl/vmicro16_branch_ctrl_pkg.sv
// vmicro16_branch_ctrl_pkg: branch condition codes, flag bit positions and resolver states
package vmicro16_branch_ctrl_pkg;
    localparam logic [7:0] BR_U  = 8'h00;
    localparam logic [7:0] BR_E  = 8'h01;
    localparam logic [7:0] BR_NE = 8'h02;
    localparam logic [7:0] BR_G  = 8'h03;
    localparam logic [7:0] BR_L  = 8'h04;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_RESOLVE, ST_FLUSH} state_e;
endpackage

// File: rtl/vmicro16_branch_cond.sv
// vmicro16_branch_cond: combinational {N,Z,C,V} x condition code -> taken
module vmicro16_branch_cond
    import vmicro16_branch_ctrl_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [7:0] cond,
    output logic       taken
);
    logic z, lt, unused_c;
    assign unused_c = flags[FLAG_C];
    always_comb begin
        z     = flags[FLAG_Z];
        lt    = flags[FLAG_N] ^ flags[FLAG_V];
        taken = (cond == BR_U)  ? 1'b1 :
                (cond == BR_E)  ? z :
                (cond == BR_NE) ? !z :
                (cond == BR_L)  ? lt :
                (cond == BR_G)  ? (!z && !lt) : 1'b0;
    end
endmodule

// File: rtl/vmicro16_branch_ctrl.sv
// vmicro16_branch_ctrl: registered branch resolver with flags register, PC redirect and timed flush
module vmicro16_branch_ctrl
    import vmicro16_branch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter bit FORWARD      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flags_we,
    input  logic [3:0]            flags_in,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [7:0]            br_cond,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  br_done,
    output logic                  taken,
    output logic                  pc_we,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  flush,
    output logic [3:0]            flags_q
);
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d, flags_d, eff_flags;
    logic                  res_q, res_d, cond_ok;
    logic [DATA_WIDTH-1:0] pc_next_q, pc_next_d;

    assign eff_flags = (FORWARD && flags_we) ? flags_in : flags_q;

    vmicro16_branch_cond u_cond (
        .flags (eff_flags),
        .cond  (br_cond),
        .taken (cond_ok)
    );

    // RESOLVE is the first flush cycle, so FLUSH only covers the remaining FLUSH_CYCLES-1
    always_comb begin
        flags_d   = flags_we ? flags_in : flags_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        pc_next_d = pc_next_q;
        case (state_q)
            ST_IDLE: if (br_valid) begin
                state_d   = ST_RESOLVE;
                res_d     = cond_ok;
                pc_next_d = cond_ok ? br_target : pc_in + DATA_WIDTH'(1);
            end
            ST_RESOLVE: begin
                cnt_d   = res_q ? CNT_INIT : 4'd0;
                state_d = (res_q && CNT_INIT != 4'd0) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q <= 4'd1) ? ST_IDLE : ST_FLUSH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            res_q     <= 1'b0;
            pc_next_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            pc_next_q <= pc_next_d;
            flags_q   <= flags_d;
        end
    end

    assign br_ready = state_q == ST_IDLE;
    assign br_done  = state_q == ST_RESOLVE;
    assign taken    = br_done && res_q;
    assign pc_we    = taken;
    assign flush    = taken || state_q == ST_FLUSH;
    assign pc_next  = pc_next_q;
endmodule

// File: tb/tb_vmicro16_branch_ctrl.sv
// tb_vmicro16_branch_ctrl: two configurations driven in lockstep, checked against a timeline model
module tb_vmicro16_branch_ctrl;
    import vmicro16_branch_ctrl_pkg::*;

    logic        clk = 1'b0, reset = 1'b0, flags_we = 1'b0, br_valid = 1'b0;
    logic [3:0]  flags_in = '0;
    logic [7:0]  br_cond = '0;
    logic [15:0] br_target = '0, pc_in = '0;
    logic        rdy[2], done[2], tk[2], we[2], fl[2];
    logic [15:0] pcn[2];
    logic [3:0]  fq[2];

    int checks = 0, errors = 0, cyc = 0;
    int fc[2] = '{2, 3};
    bit fwd[2] = '{1'b1, 1'b0};
    int ready_at[2], acc_n[2];
    bit m_tk[2];
    logic [15:0] m_pc[2];
    logic [3:0] m_fl[2];
    bit seen_tk[2];
    logic [15:0] seen_pc[2];
    bit rec = 1'b0;
    int dq0[$], dq1[$];

    always #5 clk = ~clk;

    vmicro16_branch_ctrl #(.DATA_WIDTH(16), .FLUSH_CYCLES(2), .FORWARD(1'b1)) u0 (
        .clk(clk), .reset(reset), .flags_we(flags_we), .flags_in(flags_in),
        .br_valid(br_valid), .br_ready(rdy[0]), .br_cond(br_cond), .br_target(br_target),
        .pc_in(pc_in), .br_done(done[0]), .taken(tk[0]), .pc_we(we[0]),
        .pc_next(pcn[0]), .flush(fl[0]), .flags_q(fq[0])
    );

    vmicro16_branch_ctrl #(.DATA_WIDTH(16), .FLUSH_CYCLES(3), .FORWARD(1'b0)) u1 (
        .clk(clk), .reset(reset), .flags_we(flags_we), .flags_in(flags_in),
        .br_valid(br_valid), .br_ready(rdy[1]), .br_cond(br_cond), .br_target(br_target),
        .pc_in(pc_in), .br_done(done[1]), .taken(tk[1]), .pc_we(we[1]),
        .pc_next(pcn[1]), .flush(fl[1]), .flags_q(fq[1])
    );

    // Flags read as the outcome of a compare a-b: Z means equal, N^V means signed less-than
    function automatic bit cond_ok(logic [3:0] f, logic [7:0] c);
        bit eq = f[2];
        bit lt = f[3] ^ f[0];
        if (c == BR_U)  return 1'b1;
        if (c == BR_E)  return eq;
        if (c == BR_NE) return !eq;
        if (c == BR_L)  return lt;
        if (c == BR_G)  return !eq && !lt;
        return 1'b0;
    endfunction

    task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ready_at[i] = cyc;
            acc_n[i]    = -100;
            m_tk[i]     = 1'b0;
            m_pc[i]     = '0;
            m_fl[i]     = '0;
        end
    endtask

    task automatic check_all();
        bit d;
        for (int i = 0; i < 2; i++) begin
            d = (cyc == acc_n[i]);
            chk("br_ready", i, rdy[i], cyc >= ready_at[i]);
            chk("br_done", i, done[i], d);
            chk("taken", i, tk[i], d && m_tk[i]);
            chk("pc_we", i, we[i], d && m_tk[i]);
            chk("flush", i, fl[i], m_tk[i] && cyc >= acc_n[i] && cyc < acc_n[i] + fc[i]);
            chk("pc_next", i, pcn[i], m_pc[i]);
            chk("flags_q", i, fq[i], m_fl[i]);
            if (done[i] === 1'b1) begin
                seen_tk[i] = tk[i];
                seen_pc[i] = pcn[i];
                if (rec && i == 0) dq0.push_back(cyc);
                if (rec && i == 1) dq1.push_back(cyc);
            end
        end
    endtask

    task automatic cycle();
        bit r;
        for (int i = 0; i < 2; i++) begin
            if (reset && br_valid && cyc >= ready_at[i]) begin
                r           = cond_ok((fwd[i] && flags_we) ? flags_in : m_fl[i], br_cond);
                m_tk[i]     = r;
                acc_n[i]    = cyc + 1;
                m_pc[i]     = r ? br_target : pc_in + 16'd1;
                ready_at[i] = r ? cyc + 1 + fc[i] : cyc + 2;
            end
            if (reset && flags_we) m_fl[i] = flags_in;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && !(cyc >= ready_at[0] && cyc >= ready_at[1]); k++) cycle();
    endtask

    task automatic req(logic [7:0] c, logic [15:0] t, logic [15:0] p, logic fwe, logic [3:0] fin);
        br_cond   = c;
        br_target = t;
        pc_in     = p;
        flags_we  = fwe;
        flags_in  = fin;
        br_valid  = 1'b1;
        cycle();
        br_valid  = 1'b0;
        flags_we  = 1'b0;
        drain();
    endtask

    task automatic set_flags(logic [3:0] fin);
        flags_we = 1'b1;
        flags_in = fin;
        cycle();
        flags_we = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        check_all();
        reset = 1'b1;
        cycle();

        // same-cycle flags write with BR_E: forwarded config sees Z=1, registered config sees 0
        req(BR_E, 16'h0040, 16'h0010, 1'b1, 4'b0100);
        chk("fwd_taken", 0, seen_tk[0], 1'b1);
        chk("nofwd_taken", 1, seen_tk[1], 1'b0);
        chk("nofwd_pc", 1, seen_pc[1], 16'h0011);

        set_flags(4'b1000);
        req(BR_L, 16'h0040, 16'h0010, 1'b0, 4'b0000);
        chk("bl_taken", 0, seen_tk[0], 1'b1);
        chk("bl_pc", 0, seen_pc[0], 16'h0040);
        chk("bl_taken", 1, seen_tk[1], 1'b1);

        req(BR_G, 16'h0040, 16'h0010, 1'b0, 4'b0000);
        chk("bg_taken", 0, seen_tk[0], 1'b0);
        chk("bg_pc", 0, seen_pc[0], 16'h0011);

        req(8'hEE, 16'h0777, 16'h0100, 1'b0, 4'b0000);
        chk("unk_taken", 0, seen_tk[0], 1'b0);
        req(BR_U, 16'h1234, 16'hFFFF, 1'b0, 4'b0000);
        chk("bu_taken", 1, seen_tk[1], 1'b1);
        chk("bu_pc", 1, seen_pc[1], 16'h1234);

        set_flags(4'b0100);
        req(BR_NE, 16'h0999, 16'hFFFF, 1'b0, 4'b0000);
        chk("ne_wrap_pc", 0, seen_pc[0], 16'h0000);
        chk("ne_wrap_pc", 1, seen_pc[1], 16'h0000);

        // request held through flushes; a flags write lands mid-flush
        rec       = 1'b1;
        br_cond   = BR_U;
        br_target = 16'h0200;
        pc_in     = 16'h0005;
        br_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            flags_we = (k == 2);
            flags_in = 4'b0011;
            cycle();
        end
        br_valid = 1'b0;
        flags_we = 1'b0;
        rec      = 1'b0;
        drain();
        if (dq1.size() >= 2) chk("held_gap", 1, dq1[1] - dq1[0], 4);
        else chk("held_count", 1, dq1.size(), 2);
        if (dq0.size() >= 2) chk("held_gap", 0, dq0[1] - dq0[0], 3);
        else chk("held_count", 0, dq0.size(), 2);

        // async reset in the middle of a flush
        req(BR_U, 16'h0300, 16'h0001, 1'b0, 4'b0000);
        br_valid = 1'b1;
        cycle();
        br_valid = 1'b0;
        cycle();
        chk("pre_rst_flush", 1, fl[1], 1'b1);
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_flush", i, fl[i], 1'b0);
            chk("rst_ready", i, rdy[i], 1'b1);
            chk("rst_pc_next", i, pcn[i], 16'h0000);
        end
        check_all();
        cycle();
        reset = 1'b1;
        cycle();

        for (int k = 0; k < 400; k++) begin
            int sel = int'($urandom_range(0, 5));
            br_valid  = $urandom_range(0, 1) == 1;
            br_cond   = sel == 0 ? BR_U : sel == 1 ? BR_E : sel == 2 ? BR_NE :
                        sel == 3 ? BR_G : sel == 4 ? BR_L : 8'($urandom);
            flags_we  = $urandom_range(0, 2) == 0;
            flags_in  = 4'($urandom);
            br_target = 16'($urandom);
            pc_in     = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom);
            cycle();
        end
        br_valid = 1'b0;
        flags_we = 1'b0;
        drain();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
